// File: rtl/vme_pkg.sv
// vme_pkg: shared types and constants for the VME master data-transfer sequencer.
//   - state encoding for the transfer FSM
//   - VME address-modifier codes (A24/A32 x supervisor/user x program/data)
//   - 68030 DSACK encodings
//   - cycle-kind enum plus helpers that classify a latched request and pick its AM
package vme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_ACK,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    LONG,
    WORD,
    BYTE_EVEN,
    BYTE_ODD
  } kind_t;

  localparam logic [5:0] AM_A24_SUP_DATA = 6'h3D;
  localparam logic [5:0] AM_A24_SUP_PROG = 6'h3E;
  localparam logic [5:0] AM_A24_USR_DATA = 6'h39;
  localparam logic [5:0] AM_A24_USR_PROG = 6'h3A;
  localparam logic [5:0] AM_A32_SUP_DATA = 6'h0D;
  localparam logic [5:0] AM_A32_SUP_PROG = 6'h0E;
  localparam logic [5:0] AM_A32_USR_DATA = 6'h09;
  localparam logic [5:0] AM_A32_USR_PROG = 6'h0A;

  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Only an aligned long on a D32 build is moved in one go; everything else is
  // reduced to the first legal word or byte and the CPU re-runs the remainder.
  function automatic kind_t cycle_kind(input logic [1:0] siz, input logic [1:0] addr,
                                       input logic d32);
    if (d32 && siz == 2'b00 && addr == 2'b00) return LONG;
    if (siz == 2'b01 || addr[0])               return addr[0] ? BYTE_ODD : BYTE_EVEN;
    return WORD;
  endfunction

  // fc[2] = supervisor, fc[1:0] = 10 = program space
  function automatic logic [5:0] addr_mod(input logic [2:0] fc, input logic a32);
    logic [5:0] am;
    case ({a32, fc[2], fc[1:0] == 2'b10})
      3'b000:  am = AM_A24_USR_DATA;
      3'b001:  am = AM_A24_USR_PROG;
      3'b010:  am = AM_A24_SUP_DATA;
      3'b011:  am = AM_A24_SUP_PROG;
      3'b100:  am = AM_A32_USR_DATA;
      3'b101:  am = AM_A32_USR_PROG;
      3'b110:  am = AM_A32_SUP_DATA;
      default: am = AM_A32_SUP_PROG;
    endcase
    return am;
  endfunction

endpackage

// File: rtl/vme_sync2.sv
// vme_sync2: two-flop synchroniser for an active-low asynchronous VME line.
//   clock, reset : system clock, async active-high reset (output resets to 1 = negated)
//   i_d          : asynchronous input
//   o_q          : synchronised output
module vme_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vme_master_dts.sv
// vme_master_dts: VME master data-transfer sequencer between a 68030 bus
// interface and the VME backplane drivers, started once the arbiter grants the bus.
//   CPU side : request_vme, bus_acquired, cpu_as, cpu_ds, cpu_write, cpu_siz,
//              cpu_address (A1:A0), cpu_fc in; cpu_dsack, cpu_berr out (active low)
//   VME side : vme_as, vme_ds[1:0], vme_lword, vme_write, vme_address_mod out;
//              vme_dtack, vme_berr in (asynchronous, active low)
//   Data path: data_low_oe, d16_cross_oe, md32_cross_oe (active low), data_dir
//   timeout  : one-clock pulse when the STROBE watchdog expires
// Misaligned or partial requests are shrunk to the first legal VME cycle and
// answered as a 16-bit port so the CPU finishes the rest by dynamic sizing.
module vme_master_dts import vme_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_A32       = 0,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       request_vme,
  input  logic       bus_acquired,
  input  logic       cpu_as,
  input  logic       cpu_ds,
  input  logic       cpu_write,
  input  logic [1:0] cpu_siz,
  input  logic [1:0] cpu_address,
  input  logic [2:0] cpu_fc,
  output logic [1:0] cpu_dsack,
  output logic       cpu_berr,
  output logic       vme_as,
  output logic [1:0] vme_ds,
  output logic       vme_lword,
  output logic       vme_write,
  output logic [5:0] vme_address_mod,
  input  logic       vme_dtack,
  input  logic       vme_berr,
  output logic       timeout,
  output logic       data_low_oe,
  output logic       d16_cross_oe,
  output logic       md32_cross_oe,
  output logic       data_dir
);

  localparam int CNT_MAX = (SETUP_CYCLES > RELEASE_CYCLES) ? SETUP_CYCLES : RELEASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] REL_DONE   = CW'(RELEASE_CYCLES);
  localparam logic [CW-1:0] CNT_TOP    = CW'(CNT_MAX);
  localparam logic [WW-1:0] WD_LIMIT   = WW'(TIMEOUT_CYCLES);
  localparam logic          D32        = (DATA_WIDTH == 32);

  state_t        r_state, w_next;
  logic [1:0]    r_siz, r_addr;
  logic [2:0]    r_fc;
  logic          r_write;
  logic          r_berr_resp;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_wdog;

  logic  w_dtack_s, w_berr_s;
  logic  w_start, w_wd_fire, w_rel_done, w_addr_phase, w_data_phase;
  kind_t w_kind;

  vme_sync2 u_sync_dtack (.clock(clock), .reset(reset), .i_d(vme_dtack), .o_q(w_dtack_s));
  vme_sync2 u_sync_berr  (.clock(clock), .reset(reset), .i_d(vme_berr),  .o_q(w_berr_s));

  // CPU-space cycles (fc = 111) never reach the backplane. A new cycle also
  // waits until the previous slave has released DTACK/BERR.
  assign w_start = !request_vme && !bus_acquired && !cpu_as && w_dtack_s && w_berr_s &&
                   (cpu_fc != 3'b111);
  assign w_kind     = cycle_kind(r_siz, r_addr, D32);
  assign w_wd_fire  = (r_wdog == WD_LIMIT);
  // >= because the shared counter may run past the release count when SETUP is longer
  assign w_rel_done = (r_cnt >= REL_DONE);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_SETUP;
      ST_SETUP:   if (cpu_as) w_next = ST_RELEASE;
                  else if (r_cnt >= SETUP_LAST && !cpu_ds) w_next = ST_STROBE;
      ST_STROBE:  if (cpu_as) w_next = ST_RELEASE;
                  else if (!w_dtack_s || !w_berr_s || w_wd_fire) w_next = ST_ACK;
      ST_ACK:     if (cpu_as) w_next = ST_RELEASE;
      ST_RELEASE: if (w_rel_done && w_dtack_s && w_berr_s) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // request latch, response type, setup/release counter, watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_siz       <= 2'b00;
      r_addr      <= 2'b00;
      r_fc        <= 3'b000;
      r_write     <= 1'b1;
      r_berr_resp <= 1'b0;
      r_cnt       <= '0;
      r_wdog      <= '0;
    end else begin
      if (r_state == ST_IDLE && w_start) begin
        r_siz   <= cpu_siz;
        r_addr  <= cpu_address;
        r_fc    <= cpu_fc;
        r_write <= cpu_write;
      end
      // BERR beats a simultaneous DTACK; a watchdog exit has neither, so it is a BERR too
      if (r_state == ST_STROBE && w_next == ST_ACK)
        r_berr_resp <= !w_berr_s || w_dtack_s;
      if (r_state != w_next)     r_cnt <= '0;
      else if (r_cnt != CNT_TOP) r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_STROBE && w_next == ST_STROBE) r_wdog <= r_wdog + 1'b1;
      else                                              r_wdog <= '0;
    end
  end

  // outputs
  assign w_addr_phase = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_ACK) ||
                        (r_state == ST_RELEASE && !w_rel_done);
  assign w_data_phase = (r_state == ST_STROBE) || (r_state == ST_ACK);

  always_comb begin
    cpu_dsack       = DSACK_NONE;
    cpu_berr        = 1'b1;
    vme_as          = !w_addr_phase;
    vme_ds          = 2'b11;
    vme_lword       = 1'b1;
    vme_write       = 1'b1;
    vme_address_mod = 6'h00;
    timeout         = 1'b0;
    data_low_oe     = 1'b1;
    d16_cross_oe    = 1'b1;
    md32_cross_oe   = 1'b1;
    data_dir        = 1'b1;
    if (w_addr_phase) begin
      vme_address_mod = addr_mod(r_fc, ADDR_A32 != 0);
      vme_write       = r_write;
      vme_lword       = (w_kind != LONG);
      data_dir        = r_write;
    end
    if (w_data_phase) begin
      case (w_kind)
        LONG:      begin vme_ds = 2'b00; md32_cross_oe = 1'b0; data_low_oe = 1'b0; end
        WORD:      vme_ds = 2'b00;
        BYTE_EVEN: vme_ds = 2'b01;
        default:   vme_ds = 2'b10;
      endcase
      // the 68030 expects the addr[1]=0 half on D16-D31, VME D16 carries it on D0-D15
      if (w_kind != LONG) begin
        if (D32 && !r_addr[1]) d16_cross_oe = 1'b0;
        else                   data_low_oe  = 1'b0;
      end
    end
    if (r_state == ST_ACK) begin
      if (r_berr_resp) cpu_berr  = 1'b0;
      else             cpu_dsack = (w_kind == LONG) ? DSACK_32 : DSACK_16;
    end
    if (r_state == ST_STROBE && w_wd_fire && w_dtack_s && w_berr_s && !cpu_as)
      timeout = 1'b1;
  end

endmodule

// File: tb/tb_vme_master_dts.sv
// Bench for vme_master_dts: DUT a = D32/A24, DUT b = D16/A32, both with a
// 16-clock watchdog, driven from the same CPU/VME stimulus. Expected cycle
// responses go into a scoreboard queue and are compared when DSACK/BERR appears.
module tb_vme_master_dts;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic request_vme = 1'b1, bus_acquired = 1'b1, cpu_as = 1'b1, cpu_ds = 1'b1, cpu_write = 1'b1;
  logic [1:0] cpu_siz = 2'b00, cpu_address = 2'b00;
  logic [2:0] cpu_fc = 3'b001;
  logic vme_dtack = 1'b1, vme_berr = 1'b1;

  logic [1:0] cpu_dsack_a, vme_ds_a, cpu_dsack_b, vme_ds_b;
  logic       cpu_berr_a, vme_as_a, vme_lword_a, vme_write_a, timeout_a;
  logic       cpu_berr_b, vme_as_b, vme_lword_b, vme_write_b, timeout_b;
  logic [5:0] vme_address_mod_a, vme_address_mod_b;
  logic       data_low_oe_a, d16_cross_oe_a, md32_cross_oe_a, data_dir_a;
  logic       data_low_oe_b, d16_cross_oe_b, md32_cross_oe_b, data_dir_b;

  always #5 clock = ~clock;

  vme_master_dts #(.DATA_WIDTH(32), .ADDR_A32(0), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16),
                   .RELEASE_CYCLES(1)) u_dut_a (
    .clock(clock), .reset(reset), .request_vme(request_vme), .bus_acquired(bus_acquired),
    .cpu_as(cpu_as), .cpu_ds(cpu_ds), .cpu_write(cpu_write), .cpu_siz(cpu_siz),
    .cpu_address(cpu_address), .cpu_fc(cpu_fc), .cpu_dsack(cpu_dsack_a), .cpu_berr(cpu_berr_a),
    .vme_as(vme_as_a), .vme_ds(vme_ds_a), .vme_lword(vme_lword_a), .vme_write(vme_write_a),
    .vme_address_mod(vme_address_mod_a), .vme_dtack(vme_dtack), .vme_berr(vme_berr),
    .timeout(timeout_a), .data_low_oe(data_low_oe_a), .d16_cross_oe(d16_cross_oe_a),
    .md32_cross_oe(md32_cross_oe_a), .data_dir(data_dir_a));

  vme_master_dts #(.DATA_WIDTH(16), .ADDR_A32(1), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16),
                   .RELEASE_CYCLES(1)) u_dut_b (
    .clock(clock), .reset(reset), .request_vme(request_vme), .bus_acquired(bus_acquired),
    .cpu_as(cpu_as), .cpu_ds(cpu_ds), .cpu_write(cpu_write), .cpu_siz(cpu_siz),
    .cpu_address(cpu_address), .cpu_fc(cpu_fc), .cpu_dsack(cpu_dsack_b), .cpu_berr(cpu_berr_b),
    .vme_as(vme_as_b), .vme_ds(vme_ds_b), .vme_lword(vme_lword_b), .vme_write(vme_write_b),
    .vme_address_mod(vme_address_mod_b), .vme_dtack(vme_dtack), .vme_berr(vme_berr),
    .timeout(timeout_b), .data_low_oe(data_low_oe_b), .d16_cross_oe(d16_cross_oe_b),
    .md32_cross_oe(md32_cross_oe_b), .data_dir(data_dir_b));

  typedef struct {
    int         id;
    logic [1:0] siz;
    logic [1:0] addr;
    logic [2:0] fc;
    logic       wr;
    logic [1:0] ds_a;
    logic       lw_a;
    logic [5:0] am_a;
    logic       dlow;
    logic       d16x;
    logic       md32x;
    logic [1:0] dsack;
    logic       berr;
    logic [1:0] ds_b;
    logic       lw_b;
    logic [5:0] am_b;
    logic [1:0] dsack_b;
  } vec_t;

  localparam logic [18:0] RST_EXP = {2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 6'h00,
                                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  vec_t vecs[7];
  vec_t vt, vb, vs, mon_e;
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_ack = 1'b0;
  wire  ack_a = (cpu_dsack_a != 2'b11) || !cpu_berr_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, 32'({cpu_dsack_a, cpu_berr_a, vme_as_a, vme_ds_a, vme_lword_a, vme_write_a,
                          vme_address_mod_a, timeout_a, data_low_oe_a, d16_cross_oe_a,
                          md32_cross_oe_a, data_dir_a}), 32'(RST_EXP));
    chk({tag, "_b"}, 32'({cpu_dsack_b, cpu_berr_b, vme_as_b, vme_ds_b, vme_lword_b, vme_write_b,
                          vme_address_mod_b, timeout_b, data_low_oe_b, d16_cross_oe_b,
                          md32_cross_oe_b, data_dir_b}), 32'(RST_EXP));
  endtask

  // scoreboard consumer: compare on the first clock of every CPU acknowledge
  always @(negedge clock) begin
    if (ack_a && !prev_ack) begin
      if (sb.size() == 0) chk("sb_spurious_ack", 32'(1), 32'(0));
      else begin
        mon_e = sb.pop_front();
        chk($sformatf("v%0d_as_a", mon_e.id),    32'(vme_as_a),          32'(0));
        chk($sformatf("v%0d_ds_a", mon_e.id),    32'(vme_ds_a),          32'(mon_e.ds_a));
        chk($sformatf("v%0d_lword_a", mon_e.id), 32'(vme_lword_a),       32'(mon_e.lw_a));
        chk($sformatf("v%0d_am_a", mon_e.id),    32'(vme_address_mod_a), 32'(mon_e.am_a));
        chk($sformatf("v%0d_write_a", mon_e.id), 32'(vme_write_a),       32'(mon_e.wr));
        chk($sformatf("v%0d_dir_a", mon_e.id),   32'(data_dir_a),        32'(mon_e.wr));
        chk($sformatf("v%0d_dlow_a", mon_e.id),  32'(data_low_oe_a),     32'(mon_e.dlow));
        chk($sformatf("v%0d_d16x_a", mon_e.id),  32'(d16_cross_oe_a),    32'(mon_e.d16x));
        chk($sformatf("v%0d_md32x_a", mon_e.id), 32'(md32_cross_oe_a),   32'(mon_e.md32x));
        chk($sformatf("v%0d_dsack_a", mon_e.id), 32'(cpu_dsack_a),       32'(mon_e.dsack));
        chk($sformatf("v%0d_berr_a", mon_e.id),  32'(cpu_berr_a),        32'(mon_e.berr));
        chk($sformatf("v%0d_ds_b", mon_e.id),    32'(vme_ds_b),          32'(mon_e.ds_b));
        chk($sformatf("v%0d_lword_b", mon_e.id), 32'(vme_lword_b),       32'(mon_e.lw_b));
        chk($sformatf("v%0d_am_b", mon_e.id),    32'(vme_address_mod_b), 32'(mon_e.am_b));
        chk($sformatf("v%0d_dsack_b", mon_e.id), 32'(cpu_dsack_b),       32'(mon_e.dsack_b));
        chk($sformatf("v%0d_berr_b", mon_e.id),  32'(cpu_berr_b),        32'(mon_e.berr));
      end
    end
    prev_ack <= ack_a;
  end

  task automatic start_cyc(input vec_t v);
    cpu_siz = v.siz; cpu_address = v.addr; cpu_fc = v.fc; cpu_write = v.wr;
    request_vme = 1'b0; bus_acquired = 1'b0; cpu_as = 1'b0; cpu_ds = 1'b0;
  endtask

  task automatic end_cyc();
    cpu_as = 1'b1; cpu_ds = 1'b1; request_vme = 1'b1; bus_acquired = 1'b1;
  endtask

  task automatic wait_ds(input string name);
    for (int i = 0; i < 20; i++) begin
      if (vme_ds_a != 2'b11) break;
      @(negedge clock);
    end
    if (vme_ds_a == 2'b11) chk({name, "_ds_wait_expired"}, 32'(0), 32'(1));
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 40; i++) begin
      if (ack_a) break;
      @(negedge clock);
    end
    if (!ack_a) chk({name, "_ack_wait_expired"}, 32'(0), 32'(1));
  endtask

  // mode 0: DTACK 4 clocks after DS; 1: no response (watchdog); 2: DTACK+BERR together
  task automatic run_vec(input vec_t v, input int mode);
    string nm;
    int    n;
    nm = $sformatf("v%0d", v.id);
    sb.push_back(v);
    start_cyc(v);
    wait_ds(nm);
    if (mode == 0) begin
      repeat (4) @(negedge clock);
      vme_dtack = 1'b0;
    end else if (mode == 2) begin
      repeat (2) @(negedge clock);
      vme_dtack = 1'b0; vme_berr = 1'b0;
    end else begin
      n = 0;
      while (!timeout_a && n < 40) begin @(negedge clock); n++; end
      chk({nm, "_timeout_latency"}, 32'(n), 32'(16));
      chk({nm, "_timeout_b"}, 32'(timeout_b), 32'(1));
      @(negedge clock);
      chk({nm, "_timeout_width"}, 32'(timeout_a), 32'(0));
    end
    wait_ack(nm);
    end_cyc();
    @(negedge clock);
    chk({nm, "_as_held"}, 32'(vme_as_a), 32'(0));
    chk({nm, "_ds_neg"}, 32'(vme_ds_a), 32'(2'b11));
    chk({nm, "_ack_neg"}, 32'({cpu_dsack_a, cpu_berr_a}), 32'(3'b111));
    @(negedge clock);
    chk({nm, "_as_neg"}, 32'(vme_as_a), 32'(1));
    vme_dtack = 1'b1; vme_berr = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    bit seen;
    //            id siz    addr   fc      wr  | ds_a  lw  am_a  dlow d16x md32 dsack berr | ds_b lw am_b dsack_b
    vecs[0] = '{0, 2'b00, 2'b00, 3'b001, 1'b1, 2'b00, 1'b0, 6'h39, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 6'h09, 2'b01};
    vecs[1] = '{1, 2'b01, 2'b01, 3'b101, 1'b0, 2'b10, 1'b1, 6'h3D, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 6'h0D, 2'b01};
    vecs[2] = '{2, 2'b01, 2'b10, 3'b101, 1'b0, 2'b01, 1'b1, 6'h3D, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 6'h0D, 2'b01};
    vecs[3] = '{3, 2'b00, 2'b10, 3'b001, 1'b1, 2'b00, 1'b1, 6'h39, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 6'h09, 2'b01};
    vecs[4] = '{4, 2'b11, 2'b00, 3'b110, 1'b1, 2'b00, 1'b1, 6'h3E, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 6'h0E, 2'b01};
    vecs[5] = '{5, 2'b10, 2'b11, 3'b010, 1'b1, 2'b10, 1'b1, 6'h3A, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 6'h0A, 2'b01};
    vecs[6] = '{6, 2'b11, 2'b01, 3'b001, 1'b0, 2'b10, 1'b1, 6'h39, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 6'h09, 2'b01};
    vt      = '{7, 2'b00, 2'b00, 3'b001, 1'b1, 2'b00, 1'b0, 6'h39, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 6'h09, 2'b11};
    vb      = '{8, 2'b01, 2'b01, 3'b101, 1'b0, 2'b10, 1'b1, 6'h3D, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 6'h0D, 2'b11};
    vs      = vecs[0];
    vs.fc   = 3'b111;

    repeat (3) @(negedge clock);
    chk_reset("reset_state");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0);
    run_vec(vt, 1);
    run_vec(vb, 2);

    // CPU space never starts a VME cycle
    start_cyc(vs);
    repeat (6) @(negedge clock);
    chk("cpu_space_as_a", 32'(vme_as_a), 32'(1));
    chk("cpu_space_as_b", 32'(vme_as_b), 32'(1));
    end_cyc();
    @(negedge clock);

    // cpu_as negating during SETUP aborts with no acknowledge
    start_cyc(vecs[0]);
    @(negedge clock);
    chk("abort_as_asserted", 32'(vme_as_a), 32'(0));
    end_cyc();
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (ack_a) seen = 1'b1;
    end
    chk("abort_no_ack", 32'(seen), 32'(0));
    chk("abort_as_neg", 32'(vme_as_a), 32'(1));

    // reset in STROBE, then a stuck DTACK blocks the next cycle
    start_cyc(vecs[0]);
    wait_ds("rst_mid");
    @(negedge clock);
    reset = 1'b1; vme_dtack = 1'b0;
    #1;
    chk_reset("reset_mid_cycle");
    end_cyc();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    start_cyc(vecs[0]);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (!vme_as_a) seen = 1'b1;
    end
    chk("dtack_low_blocks_start", 32'(seen), 32'(0));
    vme_dtack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (!vme_as_a) break;
    end
    chk("start_after_dtack_high", 32'(vme_as_a), 32'(0));
    end_cyc();
    repeat (5) @(negedge clock);
    chk("final_idle_as", 32'(vme_as_a), 32'(1));
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vme_master_dts.md
Name: vme_master_dts

Overview:
- Parametrised VME master data-transfer sequencer; successor to the fixed A24/D32 transfer block.
- Sits between the 68030 bus interface and the VME backplane drivers. Runs after the arbiter reports bus ownership.
- Adds the following over the fixed block:
  - configurable port width (D16/D32) and address space (A24/A32);
  - programmable address-setup and DS-negation delays;
  - a bus timeout watchdog that produces a CPU bus error;
  - splitting of misaligned or 3-byte requests onto legal VME cycles via 68030 dynamic sizing.

Parameters:
- DATA_WIDTH, 32, VME data path width; legal values 16 or 32. With 16, cycles never use LWORD and are always answered as a 16-bit port.
- ADDR_A32, 0, 1 = emit A32 address modifiers, 0 = A24.
- SETUP_CYCLES, 2, clocks between vme_as assertion and vme_ds assertion (address/AM setup); minimum 1.
- TIMEOUT_CYCLES, 1024, clocks in STROBE with no DTACK/BERR before a timeout bus error.
- RELEASE_CYCLES, 1, minimum clocks with vme_ds negated before vme_as negates.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- request_vme  in  1  active low; CPU cycle is decoded to VME space
- bus_acquired  in  1  active low; arbiter grants the bus
- cpu_as  in  1  active low
- cpu_ds  in  1  active low
- cpu_write  in  1  1 = read, 0 = write (68030 R/W)
- cpu_siz  in  2  68030 SIZ1:0
- cpu_address  in  2  A1:A0
- cpu_fc  in  3  function code
- cpu_dsack  out  2  active low; 00 = 32-bit port, 01 = 16-bit port
- cpu_berr  out  1  active low
- vme_as  out  1  active low
- vme_ds  out  2  active low; [1] = DS1 (even byte), [0] = DS0 (odd byte)
- vme_lword  out  1  active low
- vme_write  out  1  active low
- vme_address_mod  out  6  address modifier
- vme_dtack  in  1  active low, asynchronous
- vme_berr  in  1  active low, asynchronous
- timeout  out  1  active high; one-clock pulse when the watchdog fires
- data_low_oe  out  1  active low; D0-D15 transceiver enable
- d16_cross_oe  out  1  active low; D16-D31 to D0-D15 crossing
- md32_cross_oe  out  1  active low; D16-D31 straight path (D32 only)
- data_dir  out  1  1 = VME to CPU; shared direction for all data transceivers

Behaviour:
- Reset value of every output: all active-low outputs at 1, timeout = 0, vme_address_mod = 0, data_dir = 1.
- vme_dtack and vme_berr pass through a 2-flop synchroniser before any use; only the synchronised versions are sampled.
- State machine states: IDLE, SETUP, STROBE, ACK, RELEASE.
- IDLE:
  - Entered when request_vme, bus_acquired and cpu_as are all 0 and the synchronised vme_dtack and vme_berr are both 1.
  - On that clock, latch siz, addr, fc and write, then assert vme_as and go to SETUP.
- SETUP:
  - Count SETUP_CYCLES. vme_address_mod, vme_write and vme_lword are stable from entry.
  - Go to STROBE once the count expires and cpu_ds = 0.
  - For writes, cpu_ds is already 0 by the time the count expires.
- STROBE:
  - Assert vme_ds per the cycle table below and enable the transceivers.
  - Exit on the first of:
    - synchronised dtack = 0 → ACK with dsack;
    - synchronised berr = 0 → ACK with berr;
    - watchdog reaching TIMEOUT_CYCLES → ACK with berr, and pulse timeout for 1 clock.
  - If dtack and berr are seen in the same clock, berr wins.
- ACK:
  - Drive cpu_dsack (00 for a long cycle, 01 otherwise) or cpu_berr.
  - Hold it until cpu_as = 1; then negate vme_ds and cpu_dsack/cpu_berr and go to RELEASE.
- RELEASE:
  - Hold vme_as for RELEASE_CYCLES, then negate it.
  - Return to IDLE only once synchronised dtack = 1 and berr = 1.
- Cycle table (decided from latched siz and addr):
  - Long: DATA_WIDTH = 32, siz = 00, addr = 00. vme_ds = 00, vme_lword = 0, md32_cross_oe = 0, data_low_oe = 0.
  - Word: siz = 10, or siz = 00 or 11 with even addr, or siz = 00 on a D16 build; addr[0] = 0. vme_ds = 00, lword = 1.
  - Byte: siz = 01, or siz = 10 or 11 at an odd address, or siz = 00 at an odd address. DS1 is asserted when addr[0] = 0, DS0 when addr[0] = 1; lword = 1.
  - Word or byte at addr[1] = 0 on a D32 build: d16_cross_oe = 0, data_low_oe = 1. Otherwise data_low_oe = 0.
  - Any non-long cycle answers with dsack = 01, so the CPU completes the remainder by dynamic sizing.
- Address modifier (fc[2] = supervisor, fc[1:0] = 10 means program):
  - A24: 3D supervisor data, 3E supervisor program, 39 user data, 3A user program.
  - A32: 0D supervisor data, 0E supervisor program, 09 user data, 0A user program.
  - fc = 111 (CPU space) never starts a cycle; the block stays in IDLE.
- Early termination: cpu_as negating in SETUP or STROBE aborts to RELEASE with no DSACK or BERR driven.
- Reset mid-cycle: reset acts asynchronously; every output returns to its reset value within the same clock.
- Watchdog width is clog2(TIMEOUT_CYCLES + 1). It counts only in STROBE and clears on every STROBE entry.

Decomposition:
- Shared package vme_pkg holds:
  - state encoding;
  - the AM constants (A24/A32 × supervisor/user × program/data);
  - DSACK encodings (DSACK_32 = 00, DSACK_16 = 01, DSACK_NONE = 11);
  - the cycle-kind enum LONG/WORD/BYTE_EVEN/BYTE_ODD.
- One sub-module, vme_sync2: 2-flop synchroniser with set-to-1 async reset, instantiated for dtack and berr.

Test Plan:
- D32, A24, user data, siz = 00, addr = 00 read; dtack 4 clocks after DS → vme_ds = 00, lword = 0, am = 39, md32_cross_oe = 0, cpu_dsack = 00; vme_as high after cpu_as negates plus RELEASE_CYCLES.
- siz = 01, addr = 01 supervisor write → vme_ds = 10, lword = 1, am = 3D, vme_write = 0, d16_cross_oe = 0, cpu_dsack = 01; repeat with addr = 10 → vme_ds = 01, data_low_oe = 0.
- siz = 00, addr = 10 on D32, and siz = 00, addr = 00 with DATA_WIDTH = 16 → word cycle, vme_ds = 00, lword = 1, cpu_dsack = 01.
- No dtack, TIMEOUT_CYCLES = 16 → timeout pulses exactly 16 clocks after STROBE entry; cpu_berr = 0, cpu_dsack = 11; repeat with vme_berr asserted on the same clock as dtack → berr path taken.
- ADDR_A32 = 1, supervisor program fetch (fc = 110) → am = 0E; fc = 111 → vme_as stays 1.
- Reset asserted in STROBE → all outputs at reset values in the same clock; dtack held low after reset → no new cycle until it goes high.
